// File: rtl/gcd_stein.sv
// Binary (Stein) GCD engine with ld/rdy handshake, busy/drop status and a
// per-operation cycle count.
module gcd_stein #(
   parameter int WIDTH = 8,
   parameter int CNTW  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ld,
   output logic [WIDTH-1:0] q,
   output logic             rdy,
   output logic             busy,
   output logic             drop,
   output logic [CNTW-1:0]  cycles
);

   localparam int KW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, STRIP, REDUCE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d, y_q, y_d, q_q, q_d;
   logic [KW-1:0]    k_q, k_d;
   logic [CNTW-1:0]  cnt_q, cnt_d, cycles_q, cycles_d, cnt_inc;
   logic             rdy_q, rdy_d, drop_q, drop_d;

   assign busy    = (state_q != IDLE);
   assign q       = q_q;
   assign rdy     = rdy_q;
   assign drop    = drop_q;
   assign cycles  = cycles_q;
   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      k_d      = k_q;
      cnt_d    = cnt_q;
      q_d      = q_q;
      cycles_d = cycles_q;
      rdy_d    = 1'b0;
      drop_d   = ld && busy;
      case (state_q)
         IDLE: begin
            if (ld) begin
               // A zero operand makes the answer the other operand; skip the datapath.
               if (a == '0 || b == '0) begin
                  q_d      = a | b;
                  rdy_d    = 1'b1;
                  cycles_d = '0;
               end else begin
                  x_d     = a;
                  y_d     = b;
                  k_d     = '0;
                  cnt_d   = '0;
                  state_d = STRIP;
               end
            end
         end
         STRIP: begin
            cnt_d = cnt_inc;
            if (!x_q[0] && !y_q[0]) begin
               x_d = x_q >> 1;
               y_d = y_q >> 1;
               k_d = k_q + 1'b1;
            end else begin
               state_d = REDUCE;
            end
         end
         REDUCE: begin
            cnt_d = cnt_inc;
            if (x_q == y_q) begin
               q_d      = x_q << k_q;
               rdy_d    = 1'b1;
               cycles_d = cnt_inc;
               state_d  = IDLE;
            end else if (!x_q[0]) begin
               x_d = x_q >> 1;
            end else if (!y_q[0]) begin
               y_d = y_q >> 1;
            end else if (x_q > y_q) begin
               x_d = (x_q - y_q) >> 1;
            end else begin
               y_d = (y_q - x_q) >> 1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         k_q      <= '0;
         cnt_q    <= '0;
         q_q      <= '0;
         cycles_q <= '0;
         rdy_q    <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         k_q      <= k_d;
         cnt_q    <= cnt_d;
         q_q      <= q_d;
         cycles_q <= cycles_d;
         rdy_q    <= rdy_d;
         drop_q   <= drop_d;
      end
   end

endmodule

// File: tb/tb_gcd_stein.sv
// Directed bench for gcd_stein: an 8-bit and a 16-bit instance share clock/reset.
module tb_gcd_stein;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0, q8;
   logic        ld8 = 1'b0, rdy8, busy8, drop8;
   logic [7:0]  cyc8;
   logic [15:0] a16 = '0, b16 = '0, q16;
   logic        ld16 = 1'b0, rdy16, busy16, drop16;
   logic [7:0]  cyc16;

   int vectors = 0;
   int miscompares = 0;
   int rdy_cnt8 = 0, drop_cnt8 = 0, rdy_cnt16 = 0;

   always #5 clk = ~clk;

   gcd_stein #(.WIDTH(8), .CNTW(8)) u_dut8 (
      .clk(clk), .reset(reset), .a(a8), .b(b8), .ld(ld8),
      .q(q8), .rdy(rdy8), .busy(busy8), .drop(drop8), .cycles(cyc8)
   );

   gcd_stein #(.WIDTH(16), .CNTW(8)) u_dut16 (
      .clk(clk), .reset(reset), .a(a16), .b(b16), .ld(ld16),
      .q(q16), .rdy(rdy16), .busy(busy16), .drop(drop16), .cycles(cyc16)
   );

   always @(negedge clk) begin
      if (rdy8)  rdy_cnt8  <= rdy_cnt8 + 1;
      if (drop8) drop_cnt8 <= drop_cnt8 + 1;
      if (rdy16) rdy_cnt16 <= rdy_cnt16 + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int gcd_ref(input int x, input int y);
      int t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Pulses ld for one edge; returns at the negedge just after the accept edge.
   task automatic issue8(input logic [7:0] ia, input logic [7:0] ib);
      @(negedge clk);
      a8 = ia; b8 = ib; ld8 = 1'b1;
      @(negedge clk);
      ld8 = 1'b0;
   endtask

   // Counts edges after the accept edge until rdy; busy must hold until then.
   task automatic wait8(input string tag, output int n, output bit busy_ok);
      n = 0;
      busy_ok = 1'b1;
      while (!rdy8 && n < 200) begin
         if (!busy8) busy_ok = 1'b0;
         @(negedge clk);
         n++;
      end
      if (rdy8 && busy8) busy_ok = 1'b0;
      chk({tag, "_timeout"}, 32'(rdy8), 32'd1);
   endtask

   initial begin
      int n, r0, d0;
      bit bok;
      logic [7:0] ra, rb;

      #12;
      chk("rst_q", 32'(q8), 32'd0);
      chk("rst_rdy", 32'(rdy8), 32'd0);
      chk("rst_busy", 32'(busy8), 32'd0);
      chk("rst_drop", 32'(drop8), 32'd0);
      chk("rst_cycles", 32'(cyc8), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // 48,18 -> 6
      #1 r0 = rdy_cnt8; d0 = drop_cnt8;
      issue8(8'd48, 8'd18);
      wait8("g48_18", n, bok);
      chk("g48_18_q", 32'(q8), 32'd6);
      chk("g48_18_busy", 32'(bok), 32'd1);
      chk("g48_18_cycles", 32'(cyc8), 32'(n));
      @(negedge clk); #1;
      chk("g48_18_rdycnt", 32'(rdy_cnt8 - r0), 32'd1);
      chk("g48_18_nodrop", 32'(drop_cnt8 - d0), 32'd0);

      // 255,255: minimum nonzero latency
      issue8(8'd255, 8'd255);
      wait8("g255", n, bok);
      chk("g255_lat", 32'(n), 32'd2);
      chk("g255_q", 32'(q8), 32'd255);
      chk("g255_cycles", 32'(cyc8), 32'd2);

      // zero operands short-circuit
      issue8(8'd0, 8'd35);
      chk("z35_rdy", 32'(rdy8), 32'd1);
      chk("z35_q", 32'(q8), 32'd35);
      chk("z35_cycles", 32'(cyc8), 32'd0);
      chk("z35_busy", 32'(busy8), 32'd0);
      #1 r0 = rdy_cnt8;
      issue8(8'd0, 8'd0);
      chk("z0_rdy", 32'(rdy8), 32'd1);
      chk("z0_q", 32'(q8), 32'd0);
      @(negedge clk); @(negedge clk); #1;
      chk("z0_rdycnt", 32'(rdy_cnt8 - r0), 32'd1);

      // ld while busy is dropped
      #1 r0 = rdy_cnt8;
      issue8(8'd200, 8'd75);
      a8 = 8'd9; b8 = 8'd6; ld8 = 1'b1;
      @(negedge clk);
      ld8 = 1'b0;
      chk("drop_pulse", 32'(drop8), 32'd1);
      @(negedge clk);
      chk("drop_clear", 32'(drop8), 32'd0);
      wait8("drop_op", n, bok);
      chk("drop_q", 32'(q8), 32'd25);
      @(negedge clk); @(negedge clk); #1;
      chk("drop_rdycnt", 32'(rdy_cnt8 - r0), 32'd1);

      // 16-bit: twelve common factors of two
      @(negedge clk);
      a16 = 16'd40960; b16 = 16'd12288; ld16 = 1'b1;
      @(negedge clk);
      ld16 = 1'b0;
      n = 0;
      while (!rdy16 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("w16_timeout", 32'(rdy16), 32'd1);
      chk("w16_q", 32'(q16), 32'd4096);
      chk("w16_cycles", 32'(cyc16), 32'd17);
      @(negedge clk); @(negedge clk); #1;
      chk("w16_rdycnt", 32'(rdy_cnt16), 32'd1);

      // reset mid-operation aborts
      #1 r0 = rdy_cnt8;
      issue8(8'd97, 8'd89);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort_q", 32'(q8), 32'd0);
      chk("abort_busy", 32'(busy8), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      chk("abort_nordy", 32'(rdy_cnt8 - r0), 32'd0);
      chk("abort_q_hold", 32'(q8), 32'd0);
      issue8(8'd12, 8'd8);
      wait8("g12_8", n, bok);
      chk("g12_8_q", 32'(q8), 32'd4);

      // random regression against Euclid
      @(negedge clk); #1;
      r0 = rdy_cnt8;
      for (int i = 0; i < 100; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         issue8(ra, rb);
         wait8("rnd", n, bok);
         chk($sformatf("rnd_%0d_%0d", ra, rb), 32'(q8), 32'(gcd_ref(int'(ra), int'(rb))));
      end
      @(negedge clk); #1;
      chk("rnd_rdycnt", 32'(rdy_cnt8 - r0), 32'd100);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/gcd_stein.md
Name: gcd_stein

Overview:
- Parametrised successor to the 8-bit `gcd` block: computes gcd(a, b) with the binary (Stein) algorithm for any operand width.
- Adds a busy flag, a dropped-load indication, zero-operand short-circuit and a per-operation cycle count for performance tracking.
- Sits behind the same ld/rdy request-result interface, so existing gcd testbench flows (count ld, count rdy pulses) carry over unchanged.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).
- CNTW, 8, width of the cycles output; the count saturates at all-ones.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- a  input  WIDTH  operand A, sampled on an accepted ld.
- b  input  WIDTH  operand B, sampled on an accepted ld.
- ld  input  1  load request; accepted on a rising edge only when busy = 0.
- q  output  WIDTH  result register; holds the last result until the next completion.
- rdy  output  1  one-cycle pulse: q is valid and updated.
- busy  output  1  high while an operation is in progress; equals (state != IDLE).
- drop  output  1  one-cycle pulse: ld was asserted while busy = 1 and was ignored.
- cycles  output  CNTW  number of edges from the accept edge (exclusive) to the rdy edge (inclusive); updated only at completion.

Behaviour:
- Reset (reset = 0, async):
  - state = IDLE; q = 0, rdy = 0, busy = 0, drop = 0, cycles = 0.
  - Internal x, y, k and counter registers = 0.
  - Reset during an operation aborts it: no rdy is produced and q stays 0.
- Internal registers: x, y (WIDTH bits), k (clog2(WIDTH+1) bits), cnt (CNTW bits).
- rdy and drop are registered and default to 0 every cycle unless set as described below.
- State IDLE, with ld = 1:
  - If a == 0 or b == 0: q <= a | b, rdy <= 1, cycles <= 0; stay in IDLE. Latency is 1 edge.
  - Otherwise: x <= a, y <= b, k <= 0, cnt <= 0; go to STRIP.
- State STRIP (one edge per step; cnt increments on each edge, saturating):
  - If x[0] == 0 and y[0] == 0: x <= x >> 1, y <= y >> 1, k <= k + 1.
  - Otherwise go to REDUCE.
- State REDUCE (one step per edge, evaluated in priority order; cnt increments, saturating):
  1. x == y: q <= x << k, rdy <= 1, cycles <= sat(cnt + 1); go to IDLE.
  2. x even: x <= x >> 1.
  3. y even: y <= y >> 1.
  4. x > y: x <= (x - y) >> 1.
  5. Otherwise: y <= (y - x) >> 1.
- Width rules:
  - Subtraction is unsigned WIDTH-bit and never underflows, given the ordering above.
  - x << k always fits in WIDTH bits, since the result is <= min(a, b).
- ld while busy: the operands are ignored, drop <= 1 for that edge, and the current operation is unaffected.
- Back-to-back operation:
  - In the rdy cycle busy = 0, so an ld in that same cycle is accepted.
  - Peak throughput is one new operation per completion.
- Minimum latency for nonzero operands: 2 edges after the accept edge (STRIP edge plus one REDUCE edge), e.g. a == b odd.
- Worst-case cycles is bounded by about 3*WIDTH; at default parameters CNTW never saturates.

Test Plan:
- WIDTH=8, ld with a=48, b=18 -> one rdy pulse, q=6, busy high from the accept edge until the rdy edge, drop never asserted.
- a=255, b=255 -> rdy exactly 2 edges after the accept edge, q=255, cycles=2.
- a=0, b=35 -> rdy on the edge after ld, q=35, cycles=0; then a=0, b=0 -> q=0, rdy pulses once.
- Start a=200, b=75, assert ld with a=9, b=6 on the next cycle -> drop pulses 1 cycle, result q=25 (not 3), single rdy.
- WIDTH=16, a=40960, b=12288 -> q=4096; k reaches 12 in STRIP, rdy occurs once.
- Start a=97, b=89, pull reset low mid-operation -> q=0, busy=0, no rdy; after release, a=12, b=8 -> q=4.
- Random regression: 100 random pairs issued with the existing ld/rdy counting loop -> 100 rdy pulses, each q matching a reference Euclid model.
